// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, column sync/debounce,
// single-key events on a 1-deep valid/ready buffer with auto-repeat.
module keypad_scanner #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SCAN_DIV  = 1000000,
    parameter int DB_CYCLES = 524288,
    parameter int REP_DELAY = 0,
    parameter int REP_RATE  = 5000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic [ROWS-1:0]                 row_n,
    input  logic [COLS-1:0]                 col_n,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic                            key_held,
    output logic                            key_multi,
    output logic                            key_drop
);

    localparam int KEY_W = $clog2(ROWS*COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int M0    = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
    localparam int M1    = (M0 > REP_DELAY) ? M0 : REP_DELAY;
    localparam int CMAX  = (M1 > REP_RATE) ? M1 : REP_RATE;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int SD1   = SCAN_DIV - 1;
    localparam int DB1   = DB_CYCLES - 1;
    localparam int RD1   = (REP_DELAY > 0) ? REP_DELAY - 1 : 0;
    localparam int RR1   = (REP_RATE > 0) ? REP_RATE - 1 : 0;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [1:0]      state, state_d;
    logic [RW-1:0]   r, r_d, r_next;
    logic [CW-1:0]   cnt, cnt_d;
    logic [CW-1:0]   rcnt, rcnt_d;
    logic            rfirst, rfirst_d;
    logic [COLS-1:0] pat, pat_d;
    logic [COLS-1:0] s1, cols;
    logic            gen, multi;
    logic [KEY_W-1:0] code;
    int              cidx;

    assign row_n  = ~({{(ROWS-1){1'b0}}, 1'b1} << r);
    assign r_next = (r == RW'(ROWS-1)) ? '0 : r + 1'b1;

    // Key index from the frozen row and the latched one-hot column pattern
    always_comb begin
        cidx = 0;
        for (int i = 0; i < COLS; i++)
            if (pat[i]) cidx = i;
        code = KEY_W'(int'(r) * COLS + cidx);
    end

    // Scan / debounce / hold / release sequencing
    always_comb begin
        state_d  = state;
        r_d      = r;
        cnt_d    = cnt;
        pat_d    = pat;
        rcnt_d   = rcnt;
        rfirst_d = rfirst;
        gen      = 1'b0;
        multi    = 1'b0;
        unique case (state)
            SCAN: begin
                if (cols != '0) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                    pat_d   = cols;
                end else if (cnt == CW'(SD1)) begin
                    cnt_d = '0;
                    r_d   = r_next;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (cols == '0) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (cols != pat) begin
                    pat_d = cols;
                    cnt_d = '0;
                end else if (cnt == CW'(DB1)) begin
                    cnt_d = '0;
                    if ($onehot(pat)) begin
                        state_d  = PRESSED;
                        gen      = 1'b1;
                        rcnt_d   = '0;
                        rfirst_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        multi   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (cols != pat) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (REP_DELAY != 0) begin
                    if (rcnt == CW'(rfirst ? RD1 : RR1)) begin
                        gen      = 1'b1;
                        rcnt_d   = '0;
                        rfirst_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (cols != '0) begin
                    cnt_d = '0;
                end else if (cnt == CW'(DB1)) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    r_d     = r_next;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= '0;
            cols <= '0;
        end else begin
            s1   <= ~col_n;
            cols <= s1;
        end
    end

    // FSM state, row index and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= SCAN;
            r      <= '0;
            cnt    <= '0;
            rcnt   <= '0;
            rfirst <= 1'b0;
            pat    <= '0;
        end else begin
            state  <= state_d;
            r      <= r_d;
            cnt    <= cnt_d;
            rcnt   <= rcnt_d;
            rfirst <= rfirst_d;
            pat    <= pat_d;
        end
    end

    // Event buffer, drop/multi pulses and held flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_multi <= 1'b0;
            key_drop  <= 1'b0;
        end else begin
            key_multi <= multi;
            key_drop  <= 1'b0;
            key_held  <= (state_d == PRESSED);
            if (gen) begin
                if (!key_valid || key_ready) begin
                    key_valid <= 1'b1;
                    key_code  <= code;
                end else begin
                    key_drop <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: two instances, one without
// and one with auto-repeat, each driven by a small keypad model.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  row_a, col_a, code_a;
    logic        valid_a, held_a, multi_a, drop_a;
    logic        ready_a = 1'b1;
    logic [15:0] press_a = '0;

    logic [3:0]  row_b, col_b, code_b;
    logic        valid_b, held_b, multi_b, drop_b;
    logic        ready_b = 1'b1;
    logic [15:0] press_b = '0;

    int checks = 0;
    int errors = 0;
    int evt_a = 0;
    int evt_b = 0;
    int base;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DB_CYCLES(8),
        .REP_DELAY(0), .REP_RATE(10)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .row_n(row_a), .col_n(col_a),
        .key_code(code_a), .key_valid(valid_a), .key_ready(ready_a),
        .key_held(held_a), .key_multi(multi_a), .key_drop(drop_a)
    );

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DB_CYCLES(8),
        .REP_DELAY(20), .REP_RATE(10)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .row_n(row_b), .col_n(col_b),
        .key_code(code_b), .key_valid(valid_b), .key_ready(ready_b),
        .key_held(held_b), .key_multi(multi_b), .key_drop(drop_b)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_a = '1;
        col_b = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (press_a[r*4+c] && !row_a[r]) col_a[c] = 1'b0;
                if (press_b[r*4+c] && !row_b[r]) col_b[c] = 1'b0;
            end
    end

    // Count accepted handshakes
    always @(posedge clk) begin
        if (valid_a && ready_a) evt_a <= evt_a + 1;
        if (valid_b && ready_b) evt_b <= evt_b + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stop on the first negedge after the selected row becomes target
    task automatic wait_row(input bit sel, input logic [3:0] target);
        int n;
        n = 0;
        while (((sel ? row_b : row_a) === target) && n < 40) begin
            step(1);
            n++;
        end
        while (((sel ? row_b : row_a) !== target) && n < 80) begin
            step(1);
            n++;
        end
        check("wait_row", 32'((sel ? row_b : row_a) === target), 1);
    endtask

    initial begin
        logic [3:0] rows_exp [4];
        rows_exp[0] = 4'b1101;
        rows_exp[1] = 4'b1011;
        rows_exp[2] = 4'b0111;
        rows_exp[3] = 4'b1110;

        // 1: reset values, then idle scan
        step(2);
        check("rst_row", 32'(row_a), 4'b1110);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_code", 32'(code_a), 0);
        check("rst_held", 32'(held_a), 0);
        check("rst_multi", 32'(multi_a), 0);
        check("rst_drop", 32'(drop_a), 0);
        check("rst_row_b", 32'(row_b), 4'b1110);
        rst_n = 1'b1;
        step(3);
        check("scan_row0", 32'(row_a), 4'b1110);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("scan_row_sw", 32'(row_a), 32'(rows_exp[i]));
            step(3);
            check("scan_row_hold", 32'(row_a), 32'(rows_exp[i]));
            check("scan_valid", 32'(valid_a), 0);
        end

        // 2: single press row2/col1, latency 11
        wait_row(1'b0, 4'b1011);
        base = evt_a;
        press_a[9] = 1'b1;
        step(10);
        check("p2_early", 32'(valid_a), 0);
        step(1);
        check("p2_valid", 32'(valid_a), 1);
        check("p2_code", 32'(code_a), 9);
        check("p2_held", 32'(held_a), 1);
        step(1);
        check("p2_hs_drop", 32'(valid_a), 0);
        check("p2_held2", 32'(held_a), 1);
        step(38);
        press_a[9] = 1'b0;
        step(2);
        check("p2_held_rel", 32'(held_a), 1);
        step(1);
        check("p2_unheld", 32'(held_a), 0);
        step(10);
        check("p2_events", 32'(evt_a - base), 1);

        // 3: bouncing press and release
        wait_row(1'b0, 4'b1011);
        base = evt_a;
        for (int i = 0; i < 10; i++) begin
            press_a[9] = (i % 2 == 0);
            step(3);
        end
        press_a[9] = 1'b1;
        step(10);
        check("p3_early", 32'(valid_a), 0);
        step(1);
        check("p3_valid", 32'(valid_a), 1);
        check("p3_code", 32'(code_a), 9);
        step(10);
        for (int i = 0; i < 10; i++) begin
            press_a[9] = (i % 2 == 1);
            step(3);
        end
        press_a[9] = 1'b0;
        step(20);
        check("p3_events", 32'(evt_a - base), 1);
        check("p3_held", 32'(held_a), 0);

        // 4: two keys on row1 -> multi pulse, no event
        wait_row(1'b0, 4'b1101);
        base = evt_a;
        press_a[4] = 1'b1;
        press_a[7] = 1'b1;
        step(11);
        check("p4_multi", 32'(multi_a), 1);
        check("p4_valid", 32'(valid_a), 0);
        step(1);
        check("p4_multi_end", 32'(multi_a), 0);
        step(3);
        press_a[4] = 1'b0;
        press_a[7] = 1'b0;
        step(9);
        check("p4_row_frozen", 32'(row_a), 4'b1101);
        step(1);
        check("p4_row_next", 32'(row_a), 4'b1011);
        check("p4_events", 32'(evt_a - base), 0);

        // 5: consumer stalled, second event is dropped
        ready_a = 1'b0;
        wait_row(1'b0, 4'b1110);
        press_a[0] = 1'b1;
        step(11);
        check("p5_valid", 32'(valid_a), 1);
        check("p5_code0", 32'(code_a), 0);
        step(5);
        press_a[0] = 1'b0;
        step(15);
        wait_row(1'b0, 4'b1101);
        press_a[5] = 1'b1;
        step(11);
        check("p5_drop", 32'(drop_a), 1);
        check("p5_keep_valid", 32'(valid_a), 1);
        check("p5_keep_code", 32'(code_a), 0);
        step(1);
        check("p5_drop_end", 32'(drop_a), 0);
        ready_a = 1'b1;
        step(1);
        check("p5_valid_off", 32'(valid_a), 0);
        press_a[5] = 1'b0;
        step(15);

        // 6: auto-repeat on key 3, then reset mid-hold
        wait_row(1'b1, 4'b1110);
        base = evt_b;
        press_b[3] = 1'b1;
        step(11);
        check("p6_first", 32'(valid_b), 1);
        check("p6_code", 32'(code_b), 3);
        for (int k = 0; k < 4; k++) begin
            step((k == 0) ? 19 : 9);
            check("p6_gap", 32'(valid_b), 0);
            step(1);
            check("p6_rep", 32'(valid_b), 1);
            check("p6_rep_code", 32'(code_b), 3);
        end
        step(5);
        check("p6_held", 32'(held_b), 1);
        rst_n = 1'b0;
        step(1);
        check("p6_rst_valid", 32'(valid_b), 0);
        check("p6_rst_held", 32'(held_b), 0);
        check("p6_rst_row", 32'(row_b), 4'b1110);
        check("p6_rst_code", 32'(code_b), 0);
        press_b[3] = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(40);
        check("p6_events", 32'(evt_b - base), 5);
        check("p6_quiet", 32'(valid_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
